// File: rtl/spp_pkg.sv
// Shared definitions for the sequential SPP max-pool block.
// Holds the FP16 element width, the special FP16 constants, the FSM state
// encoding and the FP16 ordering-key helper used by the comparator tree.
package spp_pkg;

  localparam int          DATA_WIDTH   = 16;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] FP16_ONE     = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HPASS = 2'd1,
    VPASS = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Maps an FP16 bit pattern onto an unsigned key with the same ordering:
  // negatives are bit-inverted, non-negatives get their sign bit set.
  function automatic logic [15:0] fp16_key(input logic [15:0] v);
    logic [15:0] k;
    if (v[15]) begin
      k = ~v;
    end else begin
      k = v ^ 16'h8000;
    end
    return k;
  endfunction

endpackage

// File: rtl/spp_maxpool_seq_fp16_max5.sv
// fp16_max5: combinational maximum of five FP16 taps.
// Ports:
//   tap0_i..tap4_i  five FP16 taps, tap0 is the lowest index
//   valid_i         per-tap valid mask, bit n qualifies tapn_i
//   max_o           largest valid tap, bit pattern passed through unchanged
// Masked taps are replaced by -inf. On equal keys the lower-index tap wins,
// which the tree preserves by always keeping the left operand on a tie.
module fp16_max5
  import spp_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] tap0_i,
  input  logic [DATA_WIDTH-1:0] tap1_i,
  input  logic [DATA_WIDTH-1:0] tap2_i,
  input  logic [DATA_WIDTH-1:0] tap3_i,
  input  logic [DATA_WIDTH-1:0] tap4_i,
  input  logic [4:0]            valid_i,
  output logic [DATA_WIDTH-1:0] max_o
);

  logic [DATA_WIDTH-1:0] t0_s, t1_s, t2_s, t3_s, t4_s;
  logic [DATA_WIDTH-1:0] m01_s, m23_s, m0123_s;

  // Right operand wins only when strictly larger, so ties keep the left one.
  function automatic logic [15:0] pick(input logic [15:0] a, input logic [15:0] b);
    return (fp16_key(b) > fp16_key(a)) ? b : a;
  endfunction

  // Force masked taps to -inf so they can never win.
  always_comb begin
    t0_s = valid_i[0] ? tap0_i : FP16_NEG_INF;
    t1_s = valid_i[1] ? tap1_i : FP16_NEG_INF;
    t2_s = valid_i[2] ? tap2_i : FP16_NEG_INF;
    t3_s = valid_i[3] ? tap3_i : FP16_NEG_INF;
    t4_s = valid_i[4] ? tap4_i : FP16_NEG_INF;
  end

  // Three-level compare tree.
  always_comb begin
    m01_s   = pick(t0_s, t1_s);
    m23_s   = pick(t2_s, t3_s);
    m0123_s = pick(m01_s, m23_s);
    max_o   = pick(m0123_s, t4_s);
  end

endmodule

// File: rtl/spp_maxpool_seq.sv
// spp_maxpool_seq: sequential 5/9/13 max-pool stage of SPP.
// Captures one flat FP16 map on start, then runs three cascaded separable
// 5x5 pools (horizontal pass into tmp, vertical pass into the stage output and
// back into src), so m9 = pool5(m5) and m13 = pool5(m9).
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    run request, honoured only in IDLE
//   x        input map, element 0 in the MSBs, order ch, row, col
//   busy     high while a run is in HPASS/VPASS
//   done     one-cycle pulse when all three outputs are valid
//   out_m5   5x5 pool result, same layout as x
//   out_m9   9x9 pool result
//   out_m13  13x13 pool result
module spp_maxpool_seq
  import spp_pkg::*;
#(
  parameter int K = 1,
  parameter int H = 2,
  parameter int W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K*H*W*DATA_WIDTH-1:0] x,
  output logic                        busy,
  output logic                        done,
  output logic [K*H*W*DATA_WIDTH-1:0] out_m5,
  output logic [K*H*W*DATA_WIDTH-1:0] out_m9,
  output logic [K*H*W*DATA_WIDTH-1:0] out_m13
);

  localparam int N  = K * H * W;
  localparam int NB = N * DATA_WIDTH;
  localparam int IW = $clog2(N + 1);
  localparam int CW = $clog2(W + 1);
  localparam int RW = $clog2(H + 1);
  localparam int KW = $clog2(K + 1);

  state_e        state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic [KW-1:0] ch_q, ch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [NB-1:0] src_q, tmp_q, m5_q, m9_q, m13_q;

  logic                  cap_s, tmp_we_s, dst_we_s, last_s;
  logic [DATA_WIDTH-1:0] tap_s [5];
  logic [4:0]            valid_s;
  logic [DATA_WIDTH-1:0] max_s;
  int                    wr_off_s;

  assign last_s = (idx_q == IW'(N - 1));

  // Gather the five window taps: along the row in HPASS (from src), along the
  // column in VPASS (from tmp). Taps outside the map are masked.
  always_comb begin
    int rr, cc, addr, off;
    rr      = 0;
    cc      = 0;
    addr    = 0;
    off     = 0;
    valid_s = 5'b00000;
    for (int t = 0; t < 5; t++) begin
      tap_s[t] = FP16_NEG_INF;
      if (state_q == VPASS) begin
        rr = int'(r_q) + t - 2;
        cc = int'(c_q);
      end else begin
        rr = int'(r_q);
        cc = int'(c_q) + t - 2;
      end
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
        valid_s[t] = 1'b1;
        addr       = int'(ch_q) * H * W + rr * W + cc;
        off        = (N - 1 - addr) * DATA_WIDTH;
        if (state_q == VPASS) begin
          tap_s[t] = tmp_q[off +: DATA_WIDTH];
        end else begin
          tap_s[t] = src_q[off +: DATA_WIDTH];
        end
      end else begin
        valid_s[t] = 1'b0;
      end
    end
  end

  // Element 0 lives in the MSBs, so the write slot counts down from the top.
  always_comb begin
    wr_off_s = (N - 1 - int'(idx_q)) * DATA_WIDTH;
  end

  fp16_max5 u_max5 (
    .tap0_i  (tap_s[0]),
    .tap1_i  (tap_s[1]),
    .tap2_i  (tap_s[2]),
    .tap3_i  (tap_s[3]),
    .tap4_i  (tap_s[4]),
    .valid_i (valid_s),
    .max_o   (max_s)
  );

  // Next-state, counter stepping and buffer write strobes.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    idx_d    = idx_q;
    c_d      = c_q;
    r_d      = r_q;
    ch_d     = ch_q;
    cap_s    = 1'b0;
    tmp_we_s = 1'b0;
    dst_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HPASS;
          stage_d = 2'd0;
          idx_d   = '0;
          c_d     = '0;
          r_d     = '0;
          ch_d    = '0;
          cap_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HPASS, VPASS: begin
        if (state_q == HPASS) begin
          tmp_we_s = 1'b1;
        end else begin
          dst_we_s = 1'b1;
        end
        if (last_s) begin
          idx_d = '0;
          c_d   = '0;
          r_d   = '0;
          ch_d  = '0;
          if (state_q == HPASS) begin
            state_d = VPASS;
          end else if (stage_q < 2'd2) begin
            state_d = HPASS;
            stage_d = stage_q + 2'd1;
          end else begin
            state_d = FIN;
          end
        end else begin
          idx_d = idx_q + IW'(1);
          if (c_q == CW'(W - 1)) begin
            c_d = '0;
            if (r_q == RW'(H - 1)) begin
              r_d  = '0;
              ch_d = ch_q + KW'(1);
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flags are registered from the next state so they line up with it.
    busy_d = (state_d == HPASS) || (state_d == VPASS);
    done_d = (state_d == FIN);
  end

  // FSM state, counters and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stage_q <= 2'd0;
      idx_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      r_q     <= r_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Map buffers. VPASS results feed back into src so the next stage pools them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      tmp_q <= '0;
      m5_q  <= '0;
      m9_q  <= '0;
      m13_q <= '0;
    end else begin
      if (cap_s) begin
        src_q <= x;
      end else if (dst_we_s) begin
        src_q[wr_off_s +: DATA_WIDTH] <= max_s;
      end
      if (tmp_we_s) begin
        tmp_q[wr_off_s +: DATA_WIDTH] <= max_s;
      end
      if (dst_we_s) begin
        case (stage_q)
          2'd0:    m5_q[wr_off_s +: DATA_WIDTH]  <= max_s;
          2'd1:    m9_q[wr_off_s +: DATA_WIDTH]  <= max_s;
          2'd2:    m13_q[wr_off_s +: DATA_WIDTH] <= max_s;
          default: m13_q <= m13_q;
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign out_m5  = m5_q;
  assign out_m9  = m9_q;
  assign out_m13 = m13_q;

endmodule

// File: tb/tb_spp_maxpool_seq.sv
module tb_spp_maxpool_seq;
  import spp_pkg::*;

  localparam int MAXW = 1568;
  localparam int NA = 4;
  localparam int NB = 49;
  localparam int NC = 98;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [NA*16-1:0] x_a = '0;
  logic [NB*16-1:0] x_b = '0;
  logic [NC*16-1:0] x_c = '0;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [NA*16-1:0] a_m5, a_m9, a_m13;
  logic [NB*16-1:0] b_m5, b_m9, b_m13;
  logic [NC*16-1:0] c_m5, c_m9, c_m13;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spp_maxpool_seq #(.K(1), .H(2), .W(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .x(x_a), .busy(busy_a), .done(done_a),
    .out_m5(a_m5), .out_m9(a_m9), .out_m13(a_m13));
  spp_maxpool_seq #(.K(1), .H(7), .W(7)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .x(x_b), .busy(busy_b), .done(done_b),
    .out_m5(b_m5), .out_m9(b_m9), .out_m13(b_m13));
  spp_maxpool_seq #(.K(2), .H(7), .W(7)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .x(x_c), .busy(busy_c), .done(done_c),
    .out_m5(c_m5), .out_m9(c_m9), .out_m13(c_m13));

  typedef struct {
    logic [63:0] x;
    logic [15:0] e;
  } vec_t;

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [MAXW-1:0] act,
                         input logic [MAXW-1:0] exp, input int n);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      int e;
      e = 0;
      for (int i = n - 1; i >= 0; i--)
        if (act[(n-1-i)*16 +: 16] != exp[(n-1-i)*16 +: 16]) e = i;
      $display("FAIL %s: element %0d got %h expected %h", name, e,
               act[(n-1-e)*16 +: 16], exp[(n-1-e)*16 +: 16]);
    end
  endtask

  function automatic logic [MAXW-1:0] put(input logic [MAXW-1:0] v, input int n,
                                          input int e, input logic [15:0] d);
    logic [MAXW-1:0] o;
    o = v;
    o[(n-1-e)*16 +: 16] = d;
    return o;
  endfunction

  function automatic logic [MAXW-1:0] fill(input int n, input logic [15:0] d);
    logic [MAXW-1:0] o;
    o = '0;
    for (int e = 0; e < n; e++) o[(n-1-e)*16 +: 16] = d;
    return o;
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Pulse start, scramble x right after accept, count cycles until done.
  task automatic launch(input int w, output int lat, output int busy_ok, output int pulse_ok);
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
    case (w)
      0: x_a = ~x_a;
      1: x_b = ~x_b;
      default: x_c = ~x_c;
    endcase
    lat = 1;
    busy_ok = 1;
    while (!done_of(w) && lat < 2000) begin
      if (!busy_of(w)) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    if (busy_of(w)) busy_ok = 0;
    @(negedge clk);
    pulse_ok = done_of(w) ? 0 : 1;
  endtask

  initial begin
    vec_t tbl[6];
    logic [MAXW-1:0] v, e5, e9, e13;
    int lat, bok, pok, dones, first;

    tbl[0] = '{64'h3C00_4000_4200_4400, 16'h4400};
    tbl[1] = '{64'hBC00_C000_C200_C400, 16'hBC00};
    tbl[2] = '{64'h8000_0000_8000_8000, 16'h0000};
    tbl[3] = '{64'hFC00_7C00_0000_FC00, 16'h7C00};
    tbl[4] = '{64'hC400_FC00_FC00_FC00, 16'hC400};
    tbl[5] = '{64'hFBFF_FC00_FC00_FBFF, 16'hFBFF};

    // Reset state
    repeat (3) @(negedge clk);
    chk_int("reset busy/done", {busy_a, done_a, busy_b, done_b, busy_c, done_c}, 0);
    chk_vec("reset a_m5|m9|m13", MAXW'(a_m5 | a_m9 | a_m13), '0, NA);
    chk_vec("reset c_m5|m9|m13", MAXW'(c_m5 | c_m9 | c_m13), '0, NC);
    reset = 1'b1;

    // 2x2 table: the 5-tap window covers the whole map
    for (int i = 0; i < 6; i++) begin
      x_a = tbl[i].x;
      launch(0, lat, bok, pok);
      chk_int($sformatf("v%0d latency", i), lat, 6 * NA + 1);
      chk_int($sformatf("v%0d busy window", i), bok, 1);
      chk_int($sformatf("v%0d done pulse", i), pok, 1);
      v = fill(NA, tbl[i].e);
      chk_vec($sformatf("v%0d m5", i), MAXW'(a_m5), v, NA);
      chk_vec($sformatf("v%0d m9", i), MAXW'(a_m9), v, NA);
      chk_vec($sformatf("v%0d m13", i), MAXW'(a_m13), v, NA);
    end

    // 7x7 single hot pixel at (3,3)
    v = put('0, NB, 24, 16'h4500);
    x_b = v[NB*16-1:0];
    e5 = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        if (r >= 1 && r <= 5 && c >= 1 && c <= 5) e5 = put(e5, NB, r * 7 + c, 16'h4500);
    launch(1, lat, bok, pok);
    chk_int("hot7 latency", lat, 6 * NB + 1);
    chk_vec("hot7 m5", MAXW'(b_m5), e5, NB);
    chk_vec("hot7 m9", MAXW'(b_m9), fill(NB, 16'h4500), NB);
    chk_vec("hot7 m13", MAXW'(b_m13), fill(NB, 16'h4500), NB);

    // Two channels with hot corners, -inf background: no channel bleed
    v = fill(NC, FP16_NEG_INF);
    v = put(v, NC, 0, FP16_ONE);
    v = put(v, NC, 49 + 48, 16'h4000);
    x_c = v[NC*16-1:0];
    e5 = fill(NC, FP16_NEG_INF);
    e9 = e5;
    e13 = e5;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        if (r <= 2 && c <= 2) e5 = put(e5, NC, r * 7 + c, FP16_ONE);
        if (r >= 4 && c >= 4) e5 = put(e5, NC, 49 + r * 7 + c, 16'h4000);
        if (r <= 4 && c <= 4) e9 = put(e9, NC, r * 7 + c, FP16_ONE);
        if (r >= 2 && c >= 2) e9 = put(e9, NC, 49 + r * 7 + c, 16'h4000);
        e13 = put(e13, NC, r * 7 + c, FP16_ONE);
        e13 = put(e13, NC, 49 + r * 7 + c, 16'h4000);
      end
    launch(2, lat, bok, pok);
    chk_int("ch2 latency", lat, 6 * NC + 1);
    chk_int("ch2 done pulse", pok, 1);
    chk_vec("ch2 m5", MAXW'(c_m5), e5, NC);
    chk_vec("ch2 m9", MAXW'(c_m9), e9, NC);
    chk_vec("ch2 m13", MAXW'(c_m13), e13, NC);

    // Start during a run is ignored
    x_a = 64'h3C00_4000_4200_4400;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    dones = 0;
    first = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done_a) begin
        dones++;
        if (first == 0) first = cyc;
      end
      if (cyc == 10) start_a = 1'b1;
      if (cyc == 11) start_a = 1'b0;
      @(negedge clk);
    end
    chk_int("ignored start: done count", dones, 1);
    chk_int("ignored start: done cycle", first, 25);
    chk_vec("hold in idle m13", MAXW'(a_m13), fill(NA, 16'h4400), NA);

    // Reset asserted mid-run
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk_vec("abort m5", MAXW'(a_m5), '0, NA);
    chk_vec("abort m9|m13", MAXW'(a_m9 | a_m13), '0, NA);
    chk_int("abort busy/done", {busy_a, done_a}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done_a || busy_a) dones++;
      @(negedge clk);
    end
    chk_int("abort: no done/busy after", dones, 0);
    launch(0, lat, bok, pok);
    chk_int("after abort latency", lat, 25);
    chk_vec("after abort m5", MAXW'(a_m5), fill(NA, 16'h4400), NA);
    chk_vec("after abort m13", MAXW'(a_m13), fill(NA, 16'h4400), NA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
